data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
Parametrised successor to the word-only data memory. Adds the following:
- RV32I sub-word stores with byte-lane masking.
- Sign- and zero-extended sub-word loads.
- Misalignment and illegal-funct3 detection.
- A valid/ready request channel with a configurable fixed response latency.
Sits in the MEM stage. The pipeline stalls on req_ready low or while waiting for rsp_valid.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, ≥ 2.
LATENCY, 1, cycles from request accept edge to rsp_valid; range 1..15.
AW, $clog2(DEPTH), word index width; derived, not overridden.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  output  1  one-cycle response pulse.
rsp_rdata  output  32  extended load data; 0 for stores and errors.
rsp_err  output  1  misaligned or illegal access; valid with rsp_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous active-low. Polarity and synchronicity are fixed.
- Reset values: state IDLE, latency counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0. Memory array is not reset; contents after reset are undefined/retained.
- FSM states:
  - IDLE: req_ready=1. Accept on req_valid & req_ready at the rising edge. Capture op, funct3, addr[1:0], error flag and read word. Load counter with LATENCY-1. Go to WAIT if LATENCY>1, else RESP.
  - WAIT: req_ready=0. Decrement counter each cycle. At 1, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle, with rsp_rdata/rsp_err. req_ready=0. Next state IDLE. No back-to-back accept in RESP.
- Throughput: one request per LATENCY+1 cycles. Only one outstanding request.
- Word index: req_addr[AW+1:2]. Bits above AW+1 are ignored, so addresses alias modulo 4*DEPTH.
- Error condition:
  - Halfword (funct3 1 or 5) with addr[0]=1.
  - Word (funct3 2) with addr[1:0]≠0.
  - funct3 ∈ {3,6,7}.
  - Loads with funct3 4/5 are legal. Stores with funct3 4/5 are illegal.
- Stores commit to the array on the accept edge, only if there is no error.
  - Byte store: wdata[7:0] replicated to all lanes; write mask 1 << addr[1:0].
  - Half store: wdata[15:0] replicated; mask 0011 or 1100 by addr[1].
  - Word store: mask 1111.
  - Unmasked bytes are unchanged.
- Loads: the full word is registered at the accept edge. Lane select and extension use the captured addr[1:0].
  - B: sign-extend selected byte.
  - BU: zero-extend selected byte.
  - H: sign-extend selected half.
  - HU: zero-extend selected half.
  - W: word unchanged.
- Read after write: a load accepted after a store's RESP sees the stored data. There is no same-cycle hazard because only one request is outstanding.
- rsp_rdata is 0 on any error and for all stores. Outside RESP, rsp_rdata/rsp_err hold their last values; consumers qualify with rsp_valid.
- Reset asserted mid-operation (WAIT or RESP): immediate return to IDLE, no rsp_valid. A store already accepted stays committed.
- req_valid while not ready is ignored. Requesters hold the request until accepted.

Optional Feature:
DMEM_BOUNDS_CHECK_EN.
- Defined: any access with req_addr[31:AW+2]≠0 is flagged as an error. No write, rsp_err=1, rsp_rdata=0.
- Undefined: upper bits are ignored and addresses alias as described above.

Test Plan:
1. Reset, then SW addr 0x08 data 0xDEADBEEF, then LW 0x08 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly LATENCY cycles after each accept.
2. After test 1, SB 0x09 data 0x000000AA, then LW 0x08 -> 0xDEADAABEF is wrong; required 0xDEADAAEF. Then LB 0x09 -> 0xFFFFFFAA, and LBU 0x09 -> 0x000000AA.
3. SH 0x0E data 0x8001, then LH 0x0E -> 0xFFFF8001, LHU 0x0E -> 0x00008001, LW 0x0C -> upper half 0x8001.
4. LW 0x06, SH 0x05, and req_funct3=3 -> rsp_err=1, rsp_rdata=0, with no memory change (verify with a following LW).
5. LATENCY=3: hold req_valid high continuously. Accepts occur every 4 cycles, req_ready is low in WAIT/RESP, and exactly one rsp_valid per accept.
6. Assert rst_n low during WAIT of a load -> no rsp_valid, req_ready=1 after release. With DMEM_BOUNDS_CHECK_EN, LW 0x100 (DEPTH=64) -> rsp_err=1. Without it, LW 0x100 returns word 0.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Data memory load/store unit: byte-masked RV32I stores, extended sub-word loads, fixed-latency valid/ready response.
// Optional build macro DMEM_BOUNDS_CHECK_EN flags any address above the array as an error instead of aliasing.
module data_memory_lsu #(
  parameter  int DEPTH   = 64,
  parameter  int LATENCY = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | ready, accepts one request
  // WAIT  | counting down the remaining latency
  // RESP  | one-cycle response pulse
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_word;
  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_we, r_err;
  logic [2:0]    r_f3;
  logic [1:0]    r_lane;
  logic [31:0]   r_hold_rdata;
  logic          r_hold_err;

  logic          w_accept, w_err, w_oob;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata, w_ext, w_rdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_idx    = req_addr[AW+1:2];
  assign w_oob    = |req_addr[31:AW+2];

  always_comb begin
    w_err = 1'b0;
    case (req_funct3)
      3'd0:    w_err = 1'b0;
      3'd1:    w_err = req_addr[0];
      3'd2:    w_err = |req_addr[1:0];
      3'd4:    w_err = req_we;
      3'd5:    w_err = req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
    if (BOUNDS_EN && w_oob) w_err = 1'b1;
  end

  // Store data is replicated to every lane; the mask picks which lanes commit.
  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        w_mask  = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_mask  = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word <= r_mem[w_idx];
      if (req_we && !w_err) begin
        for (int b = 0; b < 4; b++) begin
          if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_f3         <= 3'd0;
      r_lane       <= 2'd0;
      r_hold_rdata <= 32'd0;
      r_hold_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt  <= LAT_M1;
        r_we   <= req_we;
        r_err  <= w_err;
        r_f3   <= req_funct3;
        r_lane <= req_addr[1:0];
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RESP) begin
        r_hold_rdata <= w_rdata;
        r_hold_err   <= r_err;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (LATENCY > 1) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte = r_word[7:0];
    case (r_lane)
      2'd0: w_byte = r_word[7:0];
      2'd1: w_byte = r_word[15:8];
      2'd2: w_byte = r_word[23:16];
      2'd3: w_byte = r_word[31:24];
      default: w_byte = r_word[7:0];
    endcase
    w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
    w_ext  = 32'd0;
    case (r_f3)
      3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{16{w_half[15]}}, w_half};
      3'd2:    w_ext = r_word;
      3'd4:    w_ext = {24'd0, w_byte};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = 32'd0;
    endcase
    w_rdata = (r_err || r_we) ? 32'd0 : w_ext;
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = (r_state == S_RESP) ? w_rdata : r_hold_rdata;
  assign rsp_err   = (r_state == S_RESP) ? r_err   : r_hold_err;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu at LATENCY=3: vector table of load/store requests plus
// hand-written sequences for back-to-back holding, mid-operation reset and address aliasing/bounds.
module tb_data_memory_lsu;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_memory_lsu #(.DEPTH(64), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Called and returns at a negedge with the DUT idle afterwards.
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er);
    int n;
    int lat;
    logic [31:0] rd;
    logic er;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_err; break; end
      @(negedge clk);
    end
    chk({name, " latency"}, 32'(lat), 32'(LAT));
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " err"}, 32'(er), 32'(exp_er));
    @(negedge clk);
    chk({name, " pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] alias_exp;
    logic        alias_err;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;

    vecs.push_back('{"SW 08",    1'b1, 3'd2, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"LW 08",    1'b0, 3'd2, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"SB 09",    1'b1, 3'd0, 32'h09, 32'h000000AA, 32'h0,        1'b0});
    vecs.push_back('{"LW 08b",   1'b0, 3'd2, 32'h08, 32'h0,        32'hDEADAAEF, 1'b0});
    vecs.push_back('{"LB 09",    1'b0, 3'd0, 32'h09, 32'h0,        32'hFFFFFFAA, 1'b0});
    vecs.push_back('{"LBU 09",   1'b0, 3'd4, 32'h09, 32'h0,        32'h000000AA, 1'b0});
    vecs.push_back('{"SW 0C",    1'b1, 3'd2, 32'h0C, 32'h12345678, 32'h0,        1'b0});
    vecs.push_back('{"SH 0E",    1'b1, 3'd1, 32'h0E, 32'hFFFF8001, 32'h0,        1'b0});
    vecs.push_back('{"LH 0E",    1'b0, 3'd1, 32'h0E, 32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{"LHU 0E",   1'b0, 3'd5, 32'h0E, 32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{"LW 0C",    1'b0, 3'd2, 32'h0C, 32'h0,        32'h80015678, 1'b0});
    vecs.push_back('{"LB 0F",    1'b0, 3'd0, 32'h0F, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"LH 0A",    1'b0, 3'd1, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0});
    vecs.push_back('{"LHU 0A",   1'b0, 3'd5, 32'h0A, 32'h0,        32'h0000DEAD, 1'b0});
    vecs.push_back('{"LB 08",    1'b0, 3'd0, 32'h08, 32'h0,        32'hFFFFFFEF, 1'b0});
    vecs.push_back('{"LBU 0B",   1'b0, 3'd4, 32'h0B, 32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{"LW 06",    1'b0, 3'd2, 32'h06, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"SH 05",    1'b1, 3'd1, 32'h05, 32'h0000FFFF, 32'h0,        1'b1});
    vecs.push_back('{"LD f3=3",  1'b0, 3'd3, 32'h08, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"ST f3=3",  1'b1, 3'd3, 32'h08, 32'h11111111, 32'h0,        1'b1});
    vecs.push_back('{"SW 0A",    1'b1, 3'd2, 32'h0A, 32'h22222222, 32'h0,        1'b1});
    vecs.push_back('{"ST f3=4",  1'b1, 3'd4, 32'h08, 32'h33333333, 32'h0,        1'b1});
    vecs.push_back('{"ST f3=5",  1'b1, 3'd5, 32'h08, 32'h44444444, 32'h0,        1'b1});
    vecs.push_back('{"LH 0D",    1'b0, 3'd1, 32'h0D, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"LHU 0F",   1'b0, 3'd5, 32'h0F, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"LD f3=7",  1'b0, 3'd7, 32'h08, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"LW 08 kept", 1'b0, 3'd2, 32'h08, 32'h0,      32'hDEADAAEF, 1'b0});
    vecs.push_back('{"LW 04 kept", 1'b0, 3'd2, 32'h04, 32'h0,      32'h0,        1'b0});

    #12;
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    chk("reset err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word at 0x04 is seeded first so the misaligned SH 0x05 has a known word to leave untouched.
    do_req("SW 04", 1'b1, 3'd2, 32'h04, 32'h0, 32'h0, 1'b0);
    foreach (vecs[i])
      do_req(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);

    // Continuous request: accept every LAT+1 cycles, one response each.
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h08; req_valid = 1'b1;
    for (int c = 0; c < 3 * (LAT + 1); c++) begin
      chk($sformatf("hold ready c%0d", c), 32'(req_ready), 32'((c % (LAT + 1)) == 0));
      chk($sformatf("hold rsp c%0d", c), 32'(rsp_valid), 32'((c % (LAT + 1)) == LAT));
      if (rsp_valid) chk($sformatf("hold rdata c%0d", c), rsp_rdata, 32'hDEADAAEF);
      if (c == 3 * (LAT + 1) - 1) req_valid = 1'b0;
      @(negedge clk);
    end

    // Reset during WAIT of a load: no response, ready right away.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h08;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst ready", 32'(req_ready), 32'd1);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst rsp c%0d", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("post-rst ready c%0d", c), 32'(req_ready), 32'd1);
    end

    // Reset during WAIT of a store: the write already committed.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req("LW 10 after rst", 1'b0, 3'd2, 32'h10, 32'h0, 32'h00000055, 1'b0);

    // Address above the array: alias to word 0, or error when bounds checking is built in.
    do_req("SW 00", 1'b1, 3'd2, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    alias_exp = 32'h0; alias_err = 1'b1;
`else
    alias_exp = 32'hCAFEF00D; alias_err = 1'b0;
`endif
    do_req("LW 100", 1'b0, 3'd2, 32'h100, 32'h0, alias_exp, alias_err);
    do_req("SW 104", 1'b1, 3'd2, 32'h104, 32'h0BADBEEF, 32'h0, alias_err);
`ifdef DMEM_BOUNDS_CHECK_EN
    alias_exp = 32'h0;
`else
    alias_exp = 32'h0BADBEEF;
`endif
    do_req("LW 04 alias", 1'b0, 3'd2, 32'h04, 32'h0, alias_exp, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
